// File: rtl/prog_loader.sv
// Program loader: consumes a header/payload word stream and writes the
// instruction and data memories, can zero both memories, and finally
// releases the CPU with a sticky start flag.
//
// Stream handshake: a word transfers on a rising clk_i edge exactly when
// in_valid_i and in_ready_o are both high at that edge; in_ready_o depends
// only on internal state, never on in_valid_i, and in_data_i is ignored on
// any edge without a transfer.
module prog_loader #(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [31:0]        in_data_i,
    output logic               imem_we_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic [31:0]        imem_data_o,
    output logic               dmem_we_o,
    output logic [DMEM_AW-1:0] dmem_addr_o,
    output logic [31:0]        dmem_data_o,
    output logic               busy_o,
    output logic               start_o,
    output logic [1:0]         dbg_state
);

    // Data memory is byte addressed; its word index is two bits narrower.
    localparam int DW_AW = DMEM_AW - 2;
    // The shared word counter must cover the larger of the two memories.
    localparam int CW = (IMEM_AW > DW_AW) ? IMEM_AW : DW_AW;
    // Header address field is 8 bits; use only as many as the counter holds.
    localparam int HW = (CW < 8) ? CW : 8;

    typedef enum logic [1:0] {
        S_HDR   = 2'd0,
        S_LOAD  = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            armed;     // low for the first cycle after reset release
    logic            target;    // 0 = imem, 1 = dmem
    logic [CW-1:0]   waddr;     // current word address / clear counter
    logic [7:0]      remain;    // words left in the burst, minus one
    logic [CW-1:0]   hdr_addr;
    logic            accept;
    logic            imem_in_range;
    logic            dmem_in_range;
    logic [1:0]      cmd;
    logic            unused_bits;

    assign cmd           = in_data_i[31:30];
    assign imem_in_range = ((32'(waddr) >> IMEM_AW) == 32'd0);
    assign dmem_in_range = ((32'(waddr) >> DW_AW) == 32'd0);
    assign dbg_state     = state;
    // Header bits 29:24 and 15:8 carry no meaning.
    assign unused_bits   = ^in_data_i;

    // Resize the 8-bit header word address to the counter width.
    always_comb begin
        hdr_addr           = '0;
        hdr_addr[HW-1:0]   = in_data_i[16 +: HW];
    end

    // State register; reset aborts any burst or clear immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_HDR;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the state-derived control outputs.
    always_comb begin
        next_state = state;
        in_ready_o = 1'b0;
        busy_o     = 1'b0;
        start_o    = 1'b0;
        accept     = 1'b0;
        case (state)
            S_HDR: begin
                in_ready_o = armed;
                accept     = in_valid_i && in_ready_o;
                if (accept) begin
                    case (cmd)
                        2'b00, 2'b01: next_state = S_LOAD;
                        2'b10:        next_state = S_CLEAR;
                        default:      next_state = S_DONE;
                    endcase
                end
            end
            S_LOAD: begin
                in_ready_o = armed;
                busy_o     = 1'b1;
                accept     = in_valid_i && in_ready_o;
                if (accept && (remain == 8'd0)) begin
                    next_state = S_HDR;
                end
            end
            S_CLEAR: begin
                busy_o = 1'b1;
                if (waddr == {CW{1'b1}}) begin
                    next_state = S_HDR;
                end
            end
            default: begin
                start_o    = 1'b1;
                next_state = S_DONE;
            end
        endcase
    end

    // Datapath: burst bookkeeping and registered memory write ports.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            armed       <= 1'b0;
            target      <= 1'b0;
            waddr       <= '0;
            remain      <= '0;
            imem_we_o   <= 1'b0;
            imem_addr_o <= '0;
            imem_data_o <= '0;
            dmem_we_o   <= 1'b0;
            dmem_addr_o <= '0;
            dmem_data_o <= '0;
        end else begin
            armed     <= 1'b1;
            imem_we_o <= 1'b0;
            dmem_we_o <= 1'b0;
            case (state)
                S_HDR: begin
                    if (accept && !in_data_i[31]) begin
                        target <= in_data_i[30];
                        waddr  <= hdr_addr;
                        remain <= in_data_i[7:0];
                    end else if (accept) begin
                        waddr <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (target) begin
                            dmem_we_o   <= 1'b1;
                            dmem_addr_o <= {waddr[DW_AW-1:0], 2'b00};
                            dmem_data_o <= in_data_i;
                        end else begin
                            imem_we_o   <= 1'b1;
                            imem_addr_o <= waddr[IMEM_AW-1:0];
                            imem_data_o <= in_data_i;
                        end
                        waddr  <= waddr + CW'(1);
                        remain <= remain - 8'd1;
                    end
                end
                S_CLEAR: begin
                    imem_we_o   <= imem_in_range;
                    imem_addr_o <= waddr[IMEM_AW-1:0];
                    imem_data_o <= '0;
                    dmem_we_o   <= dmem_in_range;
                    dmem_addr_o <= {waddr[DW_AW-1:0], 2'b00};
                    dmem_data_o <= '0;
                    waddr       <= waddr + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: randomized header/payload streams,
// expected memory writes queued by a high-level model, compared by a monitor.
module tb_prog_loader;

    localparam int EW = 52;  // {kind[1:0], iaddr[7:0], daddr[9:0], data[31:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        dmem_we;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_data;
    logic        busy;
    logic        start;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    // Clock / reset
    always #5 clk = ~clk;

    prog_loader #(.IMEM_AW(8), .DMEM_AW(10)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .imem_we_o   (imem_we),
        .imem_addr_o (imem_addr),
        .imem_data_o (imem_data),
        .dmem_we_o   (dmem_we),
        .dmem_addr_o (dmem_addr),
        .dmem_data_o (dmem_data),
        .busy_o      (busy),
        .start_o     (start),
        .dbg_state   (dbg_state)
    );

    function automatic logic [EW-1:0] pack(input logic [1:0] kind, input logic [7:0] ia,
                                           input logic [9:0] da, input logic [31:0] d);
        return {kind, ia, da, d};
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every strobe cycle pops one expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1 || dmem_we === 1'b1) begin
            logic [EW-1:0] obs;
            obs = pack({dmem_we, imem_we},
                       imem_we ? imem_addr : 8'h0,
                       dmem_we ? dmem_addr : 10'h0,
                       (imem_we ? imem_data : 32'h0) | (dmem_we ? dmem_data : 32'h0));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got 0x%0h expected none at %0t", obs, $time);
            end else begin
                check_val("write", 64'(obs), 64'(exp_q.pop_front()));
            end
        end
    end

    // Driver: present one word until accepted (bounded), release valid after.
    task automatic send(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = w;
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            in_valid = 1'b0;
            check_val("send_timeout", 64'(0), 64'(1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = $urandom;
        end
    endtask

    // Model: a burst of cnt+1 words starting at word 'start', wrapping mod 256.
    task automatic do_load(input bit d, input logic [7:0] start_a, input logic [7:0] cnt,
                           input int max_gap, input logic [5:0] junk_hi, input logic [7:0] junk_mid);
        logic [7:0]  a;
        logic [31:0] w;
        send({1'b0, d, junk_hi, start_a, junk_mid, cnt});
        check_val("busy_in_load", 64'(busy), 64'(1));
        for (int i = 0; i <= int'(cnt); i++) begin
            idle($urandom_range(0, max_gap));
            w = $urandom;
            a = start_a + 8'(i);
            if (d) exp_q.push_back(pack(2'b10, 8'h0, {a, 2'b00}, w));
            else   exp_q.push_back(pack(2'b01, a, 10'h0, w));
            send(w);
        end
        check_val("busy_after_load", 64'(busy), 64'(0));
        check_val("ready_after_load", 64'(in_ready), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ctl"}, 64'({in_ready, imem_we, dmem_we, busy, start}), 64'(0));
        check_val({tag, "_addr_data"}, 64'({imem_addr, dmem_addr, imem_data}), 64'(0));
        check_val({tag, "_dmem_data"}, 64'(dmem_data), 64'(0));
    endtask

    // Main stimulus sequence
    initial begin
        int cyc;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_hold");
        rst = 1'b0;
        #1 check_val("ready_before_first_edge", 64'(in_ready), 64'(0));
        @(negedge clk);
        check_val("ready_after_first_edge", 64'(in_ready), 64'(1));
        check_val("busy_idle", 64'(busy), 64'(0));

        // Directed bursts: sequential imem, single dmem, imem wrap.
        do_load(1'b0, 8'h00, 8'd2, 0, 6'h0, 8'h0);
        do_load(1'b1, 8'h01, 8'd0, 0, 6'h0, 8'h0);
        do_load(1'b0, 8'hFF, 8'd1, 0, 6'h0, 8'h0);
        // dmem wrap with stalls, then a full 256-word imem burst.
        do_load(1'b1, 8'hFA, 8'd11, 2, 6'h2A, 8'h5C);
        do_load(1'b0, 8'h80, 8'd255, 0, 6'h3F, 8'hFF);

        // Randomized bursts with ignored header bits set randomly.
        for (int t = 0; t < 30; t++) begin
            do_load(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 9)),
                    $urandom_range(0, 3), 6'($urandom), 8'($urandom));
        end

        // Clear: 256 busy cycles with the stream held valid but not taken.
        send(32'h8000_0000);
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(pack(2'b11, 8'(i), {8'(i), 2'b00}, 32'h0));
        end
        check_val("busy_in_clear", 64'(busy), 64'(1));
        cyc = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (in_ready) begin
                in_valid = 1'b0;
                break;
            end
            cyc++;
            in_valid = 1'b1;
            in_data  = $urandom;
        end
        check_val("clear_ready_low_cycles", 64'(cyc), 64'(256));
        @(negedge clk);
        check_val("clear_writes_drained", 64'(exp_q.size()), 64'(0));

        // Load after clear still works.
        do_load(1'b0, 8'h10, 8'd3, 1, 6'h0, 8'h0);

        // Reset in the middle of a 4-word burst.
        send(32'h000A_0003);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] w;
            w = $urandom;
            exp_q.push_back(pack(2'b01, 8'h0A + 8'(i), 10'h0, w));
            send(w);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_load_reset");
        check_val("pre_reset_writes_drained", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check_val("ready_post_reset_pre_edge", 64'(in_ready), 64'(0));
        @(negedge clk);
        check_val("ready_post_reset", 64'(in_ready), 64'(1));
        // First word after reset is a header: dmem word 5 -> byte address 0x14.
        do_load(1'b1, 8'h05, 8'd0, 0, 6'h0, 8'h0);

        // GO: sticky start, stream refused, no writes.
        send(32'hC000_0000);
        check_val("start_after_go", 64'(start), 64'(1));
        check_val("ready_after_go", 64'(in_ready), 64'(0));
        check_val("busy_after_go", 64'(busy), 64'(0));
        repeat (10) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = $urandom;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_val("start_held", 64'(start), 64'(1));
        check_val("ready_held_low", 64'(in_ready), 64'(0));
        check_val("done_state", 64'(dbg_state), 64'(3));
        repeat (2) @(negedge clk);
        check_val("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter IMEM_AW, default 8, instruction-memory word-address width (256 words).
REQ-002 SHALL have parameter DMEM_AW, default 10, data-memory byte-address width (1024 bytes).
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid_i, input, 1, loader stream word valid.
REQ-006 SHALL have port in_ready_o, output, 1, loader can accept a word this cycle.
REQ-007 SHALL have port in_data_i, input, 32, loader stream word (header or payload).
REQ-008 SHALL have port imem_we_o, output, 1, instruction-memory word write strobe.
REQ-009 SHALL have port imem_addr_o, output, IMEM_AW, instruction-memory word address.
REQ-010 SHALL have port imem_data_o, output, 32, instruction word to write.
REQ-011 SHALL have port dmem_we_o, output, 1, data-memory word write strobe (4 bytes, little-endian: byte addr+0 = bits 7:0).
REQ-012 SHALL have port dmem_addr_o, output, DMEM_AW, data-memory byte address, bits 1:0 always 0.
REQ-013 SHALL have port dmem_data_o, output, 32, data word to write.
REQ-014 SHALL have port busy_o, output, 1, high in CLEAR or during a LOAD burst.
REQ-015 SHALL have port start_o, output, 1, CPU start; held high once GO is processed.

Function
REQ-016 SHALL accept a word on a rising edge only when in_valid_i and in_ready_o are both high; in_data_i is ignored otherwise.
REQ-017 SHALL use header format: [31:30] cmd (00 LOAD_I, 01 LOAD_D, 10 CLEAR, 11 GO); [23:16] start word address; [7:0] word count minus 1; other bits ignored.
REQ-018 SHALL implement states HDR, LOAD, CLEAR, DONE.
REQ-019 HDR: in_ready_o=1; on an accepted LOAD_I/LOAD_D header, latch target, address and count, then go to LOAD.
REQ-020 HDR: on accepted CLEAR, go to CLEAR; on accepted GO, go to DONE.
REQ-021 LOAD: in_ready_o=1; each accepted word produces one write; the address increments by one word modulo the memory size (255->0 wraps); after count+1 words return to HDR.
REQ-022 SHALL register write outputs: a word accepted at edge k drives we/addr/data high and valid for exactly the cycle after edge k. Back-to-back accepts produce back-to-back strobes.
REQ-023 SHALL map the word address to dmem_addr_o as {wordaddr, 2'b00}, truncated or zero-extended to DMEM_AW; for imem, the word address is truncated or zero-extended to IMEM_AW.
REQ-024 CLEAR: in_ready_o=0; write zero to every imem word and every dmem word in parallel, addresses 0 upward, one per cycle, for max(2^IMEM_AW, 2^(DMEM_AW-2)) cycles (256 at defaults); then return to HDR.
REQ-025 SHALL assert a memory's strobe in CLEAR only while that memory's address is in range.
REQ-026 DONE: in_ready_o=0, start_o=1, no writes; SHALL stay in DONE until reset.
REQ-027 SHALL never assert imem_we_o and dmem_we_o in the same cycle, except during CLEAR.
REQ-028 SHALL drive busy_o=1 in CLEAR and in LOAD, and 0 in HDR and DONE.
REQ-029 Stalls: in_valid_i low in mid-LOAD holds state, address and remaining count, with no strobe.

Reset
REQ-030 While rst_i=1, SHALL force state HDR, in_ready_o=0, all strobes 0, all addr/data outputs 0, busy_o=0 and start_o=0.
REQ-031 rst_i asserted mid-LOAD or mid-CLEAR SHALL abort immediately; memory writes already issued stay.
REQ-032 After rst_i deasserts, in_ready_o SHALL become 1 from the first cycle after the next rising edge.

Verification
REQ-033 Header 0x0000_0002 followed by 3 words A,B,C -> imem writes (0,A),(1,B),(2,C) on consecutive cycles; then back to HDR.
REQ-034 Header 0x4001_0000 followed by 0xDEADBEEF -> one dmem write with addr 0x004 and data 0xDEADBEEF.
REQ-035 Header 0x00FF_0001 followed by X,Y -> imem writes (255,X),(0,Y) (wrap).
REQ-036 Header 0x8000_0000 -> 256 cycles with in_ready_o=0 and zero writes to imem 0..255 and dmem 0x000..0x3FC; then in_ready_o=1.
REQ-037 Header 0xC000_0000 -> start_o=1 and in_ready_o=0 thereafter; further in_valid_i causes no writes.
REQ-038 rst_i pulsed after 2 of 4 LOAD words -> outputs zero during reset; the next word accepted is treated as a header.
